// File: rtl/bp_pkg.sv
// bp_pkg: shared entry record, counter constants and PC field extraction for the branch predictor
package bp_pkg;
  localparam int DBITS = 32;
  localparam int TAGBITS = 8;
  localparam int CTRBITS = 2;
  localparam logic [CTRBITS-1:0] CTR_WEAK_NT = CTRBITS'((1 << (CTRBITS - 1)) - 1);
  localparam logic [CTRBITS-1:0] CTR_MAX = '1;
  typedef struct packed {
    logic valid;
    logic jmp;
    logic [TAGBITS-1:0] tag;
    logic [DBITS-1:0] target;
  } entry_t;
  function automatic logic [DBITS-1:0] pc_field(input logic [DBITS-1:0] pc, input int lsb, input int bits);
    return (pc >> lsb) & ((DBITS'(1) << bits) - DBITS'(1));
  endfunction
endpackage

// File: rtl/sat_counter_table.sv
// sat_counter_table: direction counters with saturating train port and async read port
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDXBITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDXBITS-1:0] rd_idx,
  output logic [CTRBITS-1:0] rd_ctr,
  input  logic               wr_en,
  input  logic [IDXBITS-1:0] wr_idx,
  input  logic               wr_inc
);
  localparam int N = 1 << IDXBITS;
  logic [CTRBITS-1:0] ctr [N];
  logic [CTRBITS-1:0] cur;
  assign rd_ctr = ctr[rd_idx];
  assign cur = ctr[wr_idx];
  // reset to weakly-not-taken; train toward the outcome, clamping at both ends
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < N; i++) ctr[i] <= CTR_WEAK_NT;
    else if (wr_en)
      ctr[wr_idx] <= wr_inc ? (cur == CTR_MAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB plus bimodal/gshare direction table giving the FE next-PC
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDXBITS  = 6,
  parameter int GHRBITS  = 0,
  parameter int INSTSIZE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] lkp_pc,
  output logic             pred_taken,
  output logic [DBITS-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [DBITS-1:0] upd_pc,
  input  logic             upd_is_jmp,
  input  logic             upd_taken,
  input  logic [DBITS-1:0] upd_target,
  input  logic             upd_mispred,
  output logic [15:0]      stat_mispred
);
  localparam int ENTRIES = 1 << IDXBITS;
  localparam int GHRW = GHRBITS > 0 ? GHRBITS : 1;
  entry_t btb [ENTRIES];
  entry_t lkp_e;
  logic [GHRW-1:0] ghr;
  logic [IDXBITS-1:0] lkp_idx, upd_idx, lkp_cidx, upd_cidx, ghr_mix;
  logic [TAGBITS-1:0] lkp_tag, upd_tag;
  logic [CTRBITS-1:0] lkp_ctr;
  assign lkp_idx  = IDXBITS'(pc_field(lkp_pc, 2, IDXBITS));
  assign upd_idx  = IDXBITS'(pc_field(upd_pc, 2, IDXBITS));
  assign lkp_tag  = TAGBITS'(pc_field(lkp_pc, IDXBITS + 2, TAGBITS));
  assign upd_tag  = TAGBITS'(pc_field(upd_pc, IDXBITS + 2, TAGBITS));
  assign ghr_mix  = GHRBITS > 0 ? IDXBITS'(ghr) : '0;
  assign lkp_cidx = lkp_idx ^ ghr_mix;
  assign upd_cidx = upd_idx ^ ghr_mix;
  assign lkp_e    = btb[lkp_idx];
  sat_counter_table #(.IDXBITS(IDXBITS)) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (lkp_cidx),
    .rd_ctr (lkp_ctr),
    .wr_en  (upd_valid && !upd_is_jmp),
    .wr_idx (upd_cidx),
    .wr_inc (upd_taken)
  );
  // lookup is pure combinational read of pre-update state; JAL entries ignore the counter
  always_comb begin
    pred_taken  = lkp_e.valid && lkp_e.tag == lkp_tag && (lkp_e.jmp || lkp_ctr[CTRBITS-1]);
    pred_target = pred_taken ? lkp_e.target : lkp_pc + DBITS'(INSTSIZE);
  end
  // taken outcomes allocate or overwrite the BTB slot; not-taken leaves it alone
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].jmp   <= 1'b0;
      end
    else if (upd_valid && upd_taken)
      btb[upd_idx] <= '{valid: 1'b1, jmp: upd_is_jmp, tag: upd_tag, target: upd_target};
  // history shifts on conditional branches only; mispredict count saturates
  always_ff @(posedge clk)
    if (reset) begin
      ghr <= '0;
      stat_mispred <= '0;
    end else if (upd_valid) begin
      if (GHRBITS > 0 && !upd_is_jmp) ghr <= GHRW'({ghr, upd_taken});
      if (upd_mispred && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 1'b1;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: bimodal and gshare instances checked against an arithmetic reference model
module tb_branch_predictor;
  logic clk = 0, reset = 0;
  logic [31:0] lkp_pc = 0, upd_pc = 0, upd_target = 0;
  logic upd_valid = 0, upd_is_jmp = 0, upd_taken = 0, upd_mispred = 0;
  logic [1:0] pt;
  logic [1:0][31:0] ptg;
  logic [1:0][15:0] st;
  int n_chk = 0, n_fail = 0;
  int mv[2][64], mt[2][64], mj[2][64], mc[2][64], mghr[2], mstat[2];
  logic [31:0] mtg[2][64];

  always #5 clk = ~clk;

  branch_predictor #(.GHRBITS(0)) u_bi (
    .clk(clk), .reset(reset), .lkp_pc(lkp_pc), .pred_taken(pt[0]), .pred_target(ptg[0]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jmp(upd_is_jmp), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .stat_mispred(st[0]));
  branch_predictor #(.GHRBITS(2)) u_gs (
    .clk(clk), .reset(reset), .lkp_pc(lkp_pc), .pred_taken(pt[1]), .pred_target(ptg[1]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jmp(upd_is_jmp), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .stat_mispred(st[1]));

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction
  function automatic int m_tag(logic [31:0] pc);
    return int'((pc >> 8) & 32'd255);
  endfunction
  function automatic int m_cidx(int m, logic [31:0] pc);
    return m_idx(pc) ^ mghr[m];
  endfunction
  function automatic logic [32:0] m_pred(int m, logic [31:0] pc);
    int i = m_idx(pc);
    logic t = mv[m][i] != 0 && mt[m][i] == m_tag(pc) && (mj[m][i] != 0 || mc[m][m_cidx(m, pc)] >= 2);
    return {t, t ? mtg[m][i] : pc + 32'd4};
  endfunction
  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        mv[m][i] = 0; mj[m][i] = 0; mc[m][i] = 1;
      end
      mghr[m] = 0; mstat[m] = 0;
    end
  endtask
  task automatic m_update(input int m);
    int i = m_idx(upd_pc);
    int c = m_cidx(m, upd_pc);
    if (upd_taken) begin
      mv[m][i] = 1; mt[m][i] = m_tag(upd_pc); mtg[m][i] = upd_target; mj[m][i] = int'(upd_is_jmp);
    end
    if (!upd_is_jmp) begin
      mc[m][c] = upd_taken ? (mc[m][c] == 3 ? 3 : mc[m][c] + 1) : (mc[m][c] == 0 ? 0 : mc[m][c] - 1);
      if (m == 1) mghr[1] = ((mghr[1] << 1) | int'(upd_taken)) & 3;
    end
    if (upd_mispred && mstat[m] < 65535) mstat[m]++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_reset();
    else if (upd_valid) for (int m = 0; m < 2; m++) m_update(m);
    #1;
  endtask
  task automatic drive(input logic [31:0] lp, input logic v, input logic [31:0] pc, input logic j,
                       input logic t, input logic [31:0] tg, input logic mis);
    lkp_pc = lp; upd_valid = v; upd_pc = pc; upd_is_jmp = j; upd_taken = t; upd_target = tg; upd_mispred = mis;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(32'h100, 1, 32'h100, 0, 1, 32'h777, 1);
    tick(); tick();
    reset = 0;
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      n_chk++; if (pt[m] !== 1'b0) begin n_fail++; $display("FAIL reset_taken m%0d got %b exp 0", m, pt[m]); end
      n_chk++; if (ptg[m] !== 32'h104) begin n_fail++; $display("FAIL reset_target m%0d got %h exp 104", m, ptg[m]); end
      n_chk++; if (st[m] !== 16'h0) begin n_fail++; $display("FAIL reset_stat m%0d got %h exp 0", m, st[m]); end
    end
  endtask

  task automatic test_bimodal();
    logic [32:0] e;
    drive(32'h120, 1, 32'h120, 0, 1, 32'h200, 0);
    n_chk++; if ({pt[0], ptg[0]} !== {1'b0, 32'h124}) begin n_fail++; $display("FAIL bim_same_cycle got %b/%h exp 0/124", pt[0], ptg[0]); end
    e = m_pred(1, 32'h120);
    n_chk++; if ({pt[1], ptg[1]} !== e) begin n_fail++; $display("FAIL gs_same_cycle got %b/%h exp %b/%h", pt[1], ptg[1], e[32], e[31:0]); end
    tick();
    drive(32'h120, 0, 0, 0, 0, 0, 0);
    n_chk++; if ({pt[0], ptg[0]} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL bim_trained got %b/%h exp 1/200", pt[0], ptg[0]); end
    e = m_pred(1, 32'h120);
    n_chk++; if ({pt[1], ptg[1]} !== e) begin n_fail++; $display("FAIL gs_trained got %b/%h exp %b/%h", pt[1], ptg[1], e[32], e[31:0]); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      drive(32'h120, 1, 32'h120, 0, 1, 32'h200, 0);
      tick();
    end
    drive(32'h120, 1, 32'h120, 0, 0, 32'h200, 0);
    tick();
    drive(32'h120, 0, 0, 0, 0, 0, 0);
    n_chk++; if ({pt[0], ptg[0]} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL sat_one_nt got %b/%h exp 1/200", pt[0], ptg[0]); end
    drive(32'h120, 1, 32'h120, 0, 0, 32'h200, 0);
    tick();
    drive(32'h120, 0, 0, 0, 0, 0, 0);
    n_chk++; if ({pt[0], ptg[0]} !== {1'b0, 32'h124}) begin n_fail++; $display("FAIL sat_two_nt got %b/%h exp 0/124", pt[0], ptg[0]); end
  endtask

  task automatic test_jal();
    logic [32:0] e;
    drive(32'h140, 1, 32'h140, 1, 1, 32'h400, 0);
    tick();
    drive(32'h140, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      n_chk++; if ({pt[m], ptg[m]} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL jal m%0d got %b/%h exp 1/400", m, pt[m], ptg[m]); end
    end
    drive(32'h120, 0, 0, 0, 0, 0, 0);
    e = m_pred(1, 32'h120);
    n_chk++; if ({pt[1], ptg[1]} !== e) begin n_fail++; $display("FAIL jal_ghr got %b/%h exp %b/%h", pt[1], ptg[1], e[32], e[31:0]); end
  endtask

  task automatic test_alias();
    logic [32:0] e;
    drive(32'h120, 1, 32'h220, 0, 1, 32'h300, 0);
    tick();
    drive(32'h120, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      n_chk++; if ({pt[m], ptg[m]} !== {1'b0, 32'h124}) begin n_fail++; $display("FAIL alias_evict m%0d got %b/%h exp 0/124", m, pt[m], ptg[m]); end
    end
    drive(32'h220, 0, 0, 0, 0, 0, 0);
    n_chk++; if ({pt[0], ptg[0]} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL alias_new got %b/%h exp 1/300", pt[0], ptg[0]); end
    e = m_pred(1, 32'h220);
    n_chk++; if ({pt[1], ptg[1]} !== e) begin n_fail++; $display("FAIL alias_new_gs got %b/%h exp %b/%h", pt[1], ptg[1], e[32], e[31:0]); end
  endtask

  task automatic test_gshare();
    logic [32:0] e;
    for (int k = 0; k < 8; k++) begin
      logic t = (k % 2) == 0;
      drive(32'h180, 1, 32'h180, 0, t, 32'h800, 0);
      for (int m = 0; m < 2; m++) begin
        e = m_pred(m, 32'h180);
        n_chk++; if ({pt[m], ptg[m]} !== e) begin n_fail++; $display("FAIL gs_model k%0d m%0d got %b/%h exp %b/%h", k, m, pt[m], ptg[m], e[32], e[31:0]); end
      end
      if (k >= 4) begin
        n_chk++; if (pt[1] !== t) begin n_fail++; $display("FAIL gs_pattern k%0d got %b exp %b", k, pt[1], t); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [32:0] e;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] lp = 32'h100 + ($urandom_range(0, 31) << 4);
      logic [31:0] pc = 32'h100 + ($urandom_range(0, 31) << 4);
      logic j = $urandom_range(0, 4) == 0;
      logic t = j ? 1'b1 : 1'($urandom_range(0, 1));
      drive(lp, $urandom_range(0, 9) < 7, pc, j, t, {$urandom_range(0, 65535), 2'b00}, 1'($urandom_range(0, 2) == 0));
      for (int m = 0; m < 2; m++) begin
        e = m_pred(m, lp);
        n_chk++; if ({pt[m], ptg[m]} !== e) begin n_fail++; $display("FAIL rand_pred k%0d m%0d pc=%h got %b/%h exp %b/%h", k, m, lp, pt[m], ptg[m], e[32], e[31:0]); end
        n_chk++; if (st[m] !== 16'(mstat[m])) begin n_fail++; $display("FAIL rand_stat k%0d m%0d got %h exp %h", k, m, st[m], 16'(mstat[m])); end
      end
      tick();
    end
  endtask

  task automatic test_stat_sat();
    drive(32'h500, 1, 32'h500, 1, 1, 32'h600, 1);
    for (int k = 0; k < 70000; k++) tick();
    drive(32'h500, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      n_chk++; if (st[m] !== 16'hFFFF) begin n_fail++; $display("FAIL stat_sat m%0d got %h exp FFFF", m, st[m]); end
    end
    drive(32'h500, 1, 32'h500, 1, 1, 32'h600, 1);
    tick();
    drive(32'h500, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      n_chk++; if (st[m] !== 16'hFFFF) begin n_fail++; $display("FAIL stat_hold m%0d got %h exp FFFF", m, st[m]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [4] = '{32'h120, 32'h140, 32'h180, 32'h500};
    reset = 1;
    drive(32'h120, 1, 32'h120, 0, 1, 32'h900, 1);
    tick();
    reset = 0;
    for (int p = 0; p < 4; p++) begin
      drive(pcs[p], 0, 0, 0, 0, 0, 0);
      for (int m = 0; m < 2; m++) begin
        n_chk++; if ({pt[m], ptg[m]} !== {1'b0, pcs[p] + 32'd4}) begin n_fail++; $display("FAIL reset_mid m%0d pc=%h got %b/%h exp 0/%h", m, pcs[p], pt[m], ptg[m], pcs[p] + 32'd4); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_chk++; if (st[m] !== 16'h0) begin n_fail++; $display("FAIL reset_mid_stat m%0d got %h exp 0", m, st[m]); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_bimodal();
    test_saturation();
    test_jal();
    test_alias();
    test_gshare();
    test_random();
    test_stat_sat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
